// File: rtl/multi_port_ram.sv
// Synchronous RAM with one byte-masked write port and two registered read ports.
// A post-reset sweep clears every word, so contents are defined without initial blocks.
module multi_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] wByteEn,
  input  logic [ADDR_WIDTH-1:0]   wAddr,
  input  logic [DATA_WIDTH-1:0]   dataIn,
  input  logic                    reA,
  input  logic [ADDR_WIDTH-1:0]   rAddrA,
  input  logic                    reB,
  input  logic [ADDR_WIDTH-1:0]   rAddrB,
  output logic [DATA_WIDTH-1:0]   qA,
  output logic [DATA_WIDTH-1:0]   qB,
  output logic                    busy,
  output logic                    dbg_state
);

  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_drop;
  logic                    wr_fire;
  logic [DATA_WIDTH-1:0]   wr_old;
  logic [DATA_WIDTH-1:0]   wr_merged;
  logic [DATA_WIDTH-1:0]   rd_a_next;
  logic [DATA_WIDTH-1:0]   rd_b_next;

  assign dbg_state = state;

  // Access contract: a write or read is accepted on an edge only while busy is low;
  // while busy is high, we/reA/reB are ignored and qA/qB hold their reset value.
  always_comb begin
    wr_drop   = ZERO_REG && (wAddr == '0);
    wr_fire   = (state == READY) && we && (|wByteEn) && !wr_drop;
    wr_old    = mem[wAddr];
    wr_merged = wr_old;
    for (int i = 0; i < NBYTES; i++) begin
      if (wByteEn[i]) wr_merged[8*i +: 8] = dataIn[8*i +: 8];
    end
  end

  // Each port picks zero-word, forwarded write data, or the stored word before the register.
  always_comb begin
    rd_a_next = mem[rAddrA];
    if (ZERO_REG && (rAddrA == '0)) begin
      rd_a_next = '0;
    end else if (BYPASS && wr_fire && (rAddrA == wAddr)) begin
      rd_a_next = wr_merged;
    end
  end

  always_comb begin
    rd_b_next = mem[rAddrB];
    if (ZERO_REG && (rAddrB == '0)) begin
      rd_b_next = '0;
    end else if (BYPASS && wr_fire && (rAddrB == wAddr)) begin
      rd_b_next = wr_merged;
    end
  end

  // Storage has no reset; while rst is held the FSM sits in CLEAR at address 0,
  // so the only write possible is a zero to word 0.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_addr] <= '0;
    end else if (wr_fire) begin
      mem[wAddr] <= wr_merged;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      qA       <= '0;
      qB       <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        READY: begin
          if (reA) qA <= rd_a_next;
          if (reB) qB <= rd_b_next;
        end
        default: begin
          state <= CLEAR;
          busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_port_ram.sv
// Scoreboard bench for multi_port_ram: a write-first/zero-reg instance and a
// read-first/no-zero-reg instance share one stimulus stream.
module tb_multi_port_ram;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NB    = DW / 8;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [NB-1:0] wByteEn;
  logic [AW-1:0] wAddr;
  logic [DW-1:0] dataIn;
  logic          reA;
  logic [AW-1:0] rAddrA;
  logic          reB;
  logic [AW-1:0] rAddrB;

  logic [DW-1:0] qa_wf, qb_wf, qa_rf, qb_rf;
  logic          busy_wf, busy_rf, dbg_wf, dbg_rf;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mdl_wf [DEPTH];
  logic [DW-1:0] mdl_rf [DEPTH];
  logic [DW-1:0] hold_qa_wf, hold_qb_wf, hold_qa_rf, hold_qb_rf;
  logic [DW-1:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1, "watchdog");
  end

  multi_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_wf (
    .clk(clk), .rst(rst), .we(we), .wByteEn(wByteEn), .wAddr(wAddr), .dataIn(dataIn),
    .reA(reA), .rAddrA(rAddrA), .reB(reB), .rAddrB(rAddrB),
    .qA(qa_wf), .qB(qb_wf), .busy(busy_wf), .dbg_state(dbg_wf)
  );

  multi_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut_rf (
    .clk(clk), .rst(rst), .we(we), .wByteEn(wByteEn), .wAddr(wAddr), .dataIn(dataIn),
    .reA(reA), .rAddrA(rAddrA), .reB(reB), .rAddrB(rAddrB),
    .qA(qa_rf), .qB(qb_rf), .busy(busy_rf), .dbg_state(dbg_rf)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected port output given the currently driven write and the model's stored word.
  function automatic logic [DW-1:0] model_q(input bit bypass, input bit zero, input logic re,
                                            input logic [AW-1:0] ra, input logic [DW-1:0] held,
                                            input logic [DW-1:0] stored);
    logic [DW-1:0] r;
    if (!re) return held;
    if (zero && ra == '0) return '0;
    r = stored;
    if (bypass && we && !(zero && wAddr == '0) && ra == wAddr) begin
      for (int i = 0; i < NB; i++) if (wByteEn[i]) r[8*i +: 8] = dataIn[8*i +: 8];
    end
    return r;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < DEPTH; i++) begin
      mdl_wf[i] = '0;
      mdl_rf[i] = '0;
    end
    hold_qa_wf = '0; hold_qb_wf = '0; hold_qa_rf = '0; hold_qb_rf = '0;
  endtask

  // driver: one access edge; expectations are queued at drive time and popped after the edge
  task automatic cycle(input string tag, input logic w, input logic [NB-1:0] be,
                       input logic [AW-1:0] wa, input logic [DW-1:0] d,
                       input logic ea, input logic [AW-1:0] aa,
                       input logic eb, input logic [AW-1:0] ab);
    logic [DW-1:0] e;
    we = w; wByteEn = be; wAddr = wa; dataIn = d;
    reA = ea; rAddrA = aa; reB = eb; rAddrB = ab;
    e = model_q(1'b1, 1'b1, ea, aa, hold_qa_wf, mdl_wf[aa]); exp_q.push_back(e); hold_qa_wf = e;
    e = model_q(1'b1, 1'b1, eb, ab, hold_qb_wf, mdl_wf[ab]); exp_q.push_back(e); hold_qb_wf = e;
    e = model_q(1'b0, 1'b0, ea, aa, hold_qa_rf, mdl_rf[aa]); exp_q.push_back(e); hold_qa_rf = e;
    e = model_q(1'b0, 1'b0, eb, ab, hold_qb_rf, mdl_rf[ab]); exp_q.push_back(e); hold_qb_rf = e;
    if (w) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          if (wa != '0) mdl_wf[wa][8*i +: 8] = d[8*i +: 8];
          mdl_rf[wa][8*i +: 8] = d[8*i +: 8];
        end
      end
    end
    @(posedge clk); #1;
    check({tag, ".qa_wf"}, qa_wf, exp_q.pop_front());
    check({tag, ".qb_wf"}, qb_wf, exp_q.pop_front());
    check({tag, ".qa_rf"}, qa_rf, exp_q.pop_front());
    check({tag, ".qb_rf"}, qb_rf, exp_q.pop_front());
    we = 1'b0; wByteEn = '0; reA = 1'b0; reB = 1'b0;
  endtask

  // Asserts rst between edges and checks the outputs respond before any clock edge.
  task automatic pulse_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    check({tag, ".busy_async"}, {31'b0, busy_wf}, 32'd1);
    check({tag, ".busy_rf_async"}, {31'b0, busy_rf}, 32'd1);
    check({tag, ".qa_wf_async"}, qa_wf, '0);
    check({tag, ".qb_rf_async"}, qb_rf, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    we = 1'b0; wByteEn = '0;
    clear_models();
  endtask

  // Counts edges with rst low; reads are driven throughout to show they are ignored.
  task automatic run_sweep(input string tag, input int edges);
    reA = 1'b1; rAddrA = 5'd5; reB = 1'b1; rAddrB = 5'd9;
    for (int k = 1; k <= edges; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == DEPTH - 1) check($sformatf("%s.busy_e%0d", tag, k), {31'b0, busy_wf}, 32'd1);
      if (k == DEPTH) begin
        check({tag, ".busy_done"}, {31'b0, busy_wf}, 32'd0);
        check({tag, ".busy_rf_done"}, {31'b0, busy_rf}, 32'd0);
        check({tag, ".qa_ignored"}, qa_wf, '0);
        check({tag, ".qb_rf_ignored"}, qb_rf, '0);
      end
    end
    reA = 1'b0; reB = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < DEPTH; a++)
      cycle($sformatf("%s%0d", tag, a), 1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b1, AW'(DEPTH - 1 - a));
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; wByteEn = '0; wAddr = '0; dataIn = '0;
    reA = 1'b0; rAddrA = '0; reB = 1'b0; rAddrB = '0;
    clear_models();

    #2 rst = 1'b1;
    #1;
    check("reset.busy", {31'b0, busy_wf}, 32'd1);
    check("reset.qa", qa_wf, '0);
    check("reset.qb", qb_wf, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run_sweep("sweep0", DEPTH);

    // fill with garbage, then reset and confirm the sweep clears it
    for (int a = 0; a < DEPTH; a++)
      cycle("garbage", 1'b1, '1, AW'(a), $urandom(), 1'b0, '0, 1'b0, '0);
    cycle("garbage_rd", 1'b0, '0, '0, '0, 1'b1, 5'd12, 1'b1, 5'd0);
    pulse_reset("rst_ready");
    run_sweep("sweep1", DEPTH);
    read_all("clear_a");

    // basic write/read and hold
    cycle("wr5", 1'b1, 4'hF, 5'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0, '0);
    cycle("rd5", 1'b0, '0, '0, '0, 1'b1, 5'd5, 1'b1, 5'd5);
    check("basic.qa_const", qa_wf, 32'hDEADBEEF);
    check("basic.qb_const", qb_wf, 32'hDEADBEEF);
    cycle("hold", 1'b0, '0, '0, '0, 1'b0, 5'd7, 1'b1, 5'd7);
    check("hold.qa_const", qa_wf, 32'hDEADBEEF);

    // byte enables
    cycle("wr7", 1'b1, 4'hF, 5'd7, 32'h11223344, 1'b0, '0, 1'b0, '0);
    cycle("wr7be", 1'b1, 4'b0101, 5'd7, 32'hAABBCCDD, 1'b0, '0, 1'b0, '0);
    cycle("rd7", 1'b0, '0, '0, '0, 1'b1, 5'd7, 1'b0, '0);
    check("byteen.qa_const", qa_wf, 32'h11BB33DD);

    // collision, both modes
    cycle("wr3", 1'b1, 4'hF, 5'd3, 32'h00000001, 1'b0, '0, 1'b0, '0);
    cycle("coll3", 1'b1, 4'hF, 5'd3, 32'h00000002, 1'b1, 5'd3, 1'b1, 5'd3);
    check("coll.wf_const", qa_wf, 32'h00000002);
    check("coll.rf_const", qa_rf, 32'h00000001);
    cycle("rd3", 1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b1, 5'd3);
    check("coll_after.wf_const", qa_wf, 32'h00000002);
    check("coll_after.rf_const", qa_rf, 32'h00000002);

    // partial-mask collision and empty-mask write
    cycle("coll7p", 1'b1, 4'b1000, 5'd7, 32'h99000000, 1'b1, 5'd7, 1'b0, '0);
    check("collp.wf_const", qa_wf, 32'h99BB33DD);
    cycle("nomask", 1'b1, 4'b0000, 5'd7, 32'h12345678, 1'b1, 5'd7, 1'b1, 5'd7);
    check("nomask.wf_const", qa_wf, 32'h99BB33DD);

    // zero register
    cycle("zero_coll", 1'b1, 4'hF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    check("zero_coll.wf_const", qa_wf, 32'h0);
    cycle("zero_rd", 1'b0, '0, '0, '0, 1'b1, 5'd0, 1'b1, 5'd0);
    check("zero.wf_const", qa_wf, 32'h0);
    check("zero.rf_const", qa_rf, 32'hFFFFFFFF);

    // random traffic
    for (int n = 0; n < 60; n++)
      cycle("rand", 1'($urandom_range(0, 1)), NB'($urandom_range(0, 15)), AW'($urandom_range(0, 7)),
            $urandom(), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));

    // reset in the middle of a sweep
    pulse_reset("rst_a");
    run_sweep("sweep_part", 10);
    pulse_reset("rst_mid_sweep");
    run_sweep("sweep2", DEPTH);

    // reset in READY with a write in flight
    cycle("wr9", 1'b1, 4'hF, 5'd9, 32'hCAFEF00D, 1'b0, '0, 1'b0, '0);
    cycle("rd9", 1'b0, '0, '0, '0, 1'b1, 5'd9, 1'b1, 5'd9);
    check("rd9.qa_const", qa_wf, 32'hCAFEF00D);
    we = 1'b1; wByteEn = 4'hF; wAddr = 5'd9; dataIn = 32'h0BADF00D;
    pulse_reset("rst_mid_write");
    run_sweep("sweep3", DEPTH);
    read_all("clear_b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
